uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_tx_if.sv | 28 ++
 rtl/uart_baud_cnt.sv | 41 ++++
 rtl/uart_tx.sv | 132 +++++++++++++
 tb/tb_uart_tx.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: constants, state encodings and helpers shared by the MU0 UART transmitter and receiver.
`timescale 1ns/1ps
package uart_pkg;

   localparam int DEF_CLK_FREQ     = 50_000_000;
   localparam int DEF_UART_BPS     = 9600;
   localparam int DATA_BITS        = 8;
   localparam int FRAME_BITS_NOPAR = 10;
   localparam int FRAME_BITS_PAR   = 11;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_t;

   function automatic int calc_period(input int clk_freq, input int bps);
      return clk_freq / bps;
   endfunction

   // Keep counters at least one bit wide even for degenerate periods.
   function automatic int calc_cnt_width(input int period);
      return (period > 1) ? $clog2(period) : 1;
   endfunction

   function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte request / status handshake between core logic and the UART transmitter.
`timescale 1ns/1ps
interface uart_tx_if;
   import uart_pkg::*;

   logic                 tx_start;
   logic [DATA_BITS-1:0] tx_data;
   logic                 uart_tx;
   logic                 tx_busy;
   logic                 tx_done;

   modport master (
      output tx_start,
      output tx_data,
      input  uart_tx,
      input  tx_busy,
      input  tx_done
   );

   modport slave (
      input  tx_start,
      input  tx_data,
      output uart_tx,
      output tx_busy,
      output tx_done
   );

endinterface

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: counts clocks within one bit period and flags the last clock of each bit.
`timescale 1ns/1ps
module uart_baud_cnt
   import uart_pkg::*;
#(
   parameter int PERIOD = 10,
   parameter int CW     = calc_cnt_width(PERIOD)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   output logic [CW-1:0] cnt,
   output logic          tick
);

   localparam logic [CW-1:0] LAST_CNT = CW'(PERIOD - 1);

   logic [CW-1:0] cnt_r;

   // Period counter: restarts on clear and wraps after the last clock of a bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= {CW{1'b0}};
      end else if (clr) begin
         cnt_r <= {CW{1'b0}};
      end else if (en) begin
         if (cnt_r == LAST_CNT) begin
            cnt_r <= {CW{1'b0}};
         end else begin
            cnt_r <= cnt_r + CW'(1);
         end
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign cnt  = cnt_r;
   assign tick = en && (cnt_r == LAST_CNT);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter for the MU0 host link, LSB first, idle high.
// Define UART_TX_PARITY_EN to insert an even-parity bit after bit 7 (8E1).
`timescale 1ns/1ps
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = DEF_CLK_FREQ,
   parameter int UART_BPS = DEF_UART_BPS
) (
   input logic      clk,
   input logic      rst,
   uart_tx_if.slave bus
);

   localparam int PERIOD = calc_period(CLK_FREQ, UART_BPS);
   localparam int CW     = calc_cnt_width(PERIOD);
   localparam int BW     = $clog2(DATA_BITS);
   localparam logic [CW-1:0] DONE_CNT = CW'(PERIOD - 2);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

   uart_state_t          state_r;
   logic [DATA_BITS-1:0] shift_r;
   logic [BW-1:0]        bit_idx_r;
`ifdef UART_TX_PARITY_EN
   logic                 parity_r;
`endif
   logic                 uart_tx_r;
   logic                 tx_busy_r;
   logic                 tx_done_r;
   logic [CW-1:0]        cnt_s;
   logic                 tick_s;
   logic                 accept_s;

   // A new byte may be taken while idle or in the last stop-bit clock, giving zero-gap frames.
   assign accept_s = bus.tx_start && (!tx_busy_r || tx_done_r);

   uart_baud_cnt #(
      .PERIOD (PERIOD),
      .CW     (CW)
   ) u_baud (
      .clk  (clk),
      .rst  (rst),
      .clr  (accept_s),
      .en   (tx_busy_r),
      .cnt  (cnt_s),
      .tick (tick_s)
   );

   // Frame sequencer, shift register and registered line/status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         shift_r   <= {DATA_BITS{1'b0}};
         bit_idx_r <= {BW{1'b0}};
`ifdef UART_TX_PARITY_EN
         parity_r  <= 1'b0;
`endif
         uart_tx_r <= 1'b1;
         tx_busy_r <= 1'b0;
         tx_done_r <= 1'b0;
      end else if (accept_s) begin
         state_r   <= ST_START;
         shift_r   <= bus.tx_data;
         bit_idx_r <= {BW{1'b0}};
`ifdef UART_TX_PARITY_EN
         parity_r  <= even_parity(bus.tx_data);
`endif
         uart_tx_r <= 1'b0;
         tx_busy_r <= 1'b1;
         tx_done_r <= 1'b0;
      end else begin
         tx_done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               uart_tx_r <= 1'b1;
               tx_busy_r <= 1'b0;
            end
            ST_START: begin
               if (tick_s) begin
                  state_r   <= ST_DATA;
                  bit_idx_r <= {BW{1'b0}};
                  uart_tx_r <= shift_r[0];
               end
            end
            ST_DATA: begin
               if (tick_s) begin
                  if (bit_idx_r == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                     state_r   <= ST_PARITY;
                     uart_tx_r <= parity_r;
`else
                     state_r   <= ST_STOP;
                     uart_tx_r <= 1'b1;
`endif
                  end else begin
                     bit_idx_r <= bit_idx_r + BW'(1);
                     shift_r   <= {1'b0, shift_r[DATA_BITS-1:1]};
                     uart_tx_r <= shift_r[1];
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
               if (tick_s) begin
                  state_r   <= ST_STOP;
                  uart_tx_r <= 1'b1;
               end
            end
`endif
            ST_STOP: begin
               // Registered, so raise it one clock early to land on the final stop clock.
               tx_done_r <= (cnt_s == DONE_CNT);
               if (tick_s) begin
                  state_r   <= ST_IDLE;
                  uart_tx_r <= 1'b1;
                  tx_busy_r <= 1'b0;
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               uart_tx_r <= 1'b1;
               tx_busy_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.uart_tx = uart_tx_r;
   assign bus.tx_busy = tx_busy_r;
   assign bus.tx_done = tx_done_r;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized scoreboard bench for uart_tx with a cycle-level waveform reference model.
`timescale 1ns/1ps
module tb_uart_tx;

   localparam int CLK_FREQ = 1000;
   localparam int UART_BPS = 100;
   localparam int P        = CLK_FREQ / UART_BPS;
`ifdef UART_TX_PARITY_EN
   localparam int F = 11 * P;
`else
   localparam int F = 10 * P;
`endif

   logic clk = 1'b0;
   logic rst;

   uart_tx_if bus();

   uart_tx #(
      .CLK_FREQ (CLK_FREQ),
      .UART_BPS (UART_BPS)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      int         n;
   } frame_t;

   frame_t exp_q[$];
   frame_t cur;
   frame_t popped;
   int     errors = 0;
   int     checks = 0;
   int     cyc    = 0;
   bit     chk_en = 1'b0;
   bit     fr_valid = 1'b0;
   bit     abort  = 1'b0;

   bit         dec_active = 1'b0;
   int         dec_start  = 0;
   int         off;
   int         k;
   logic [7:0] dec_byte = 8'h00;
   logic       dec_par  = 1'b0;
   logic       el, eb, ed;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s @cycle %0d: got %0h, required %0h", nm, cyc, act, req);
      end
   endtask

   // Reference model: decides acceptance from the frame timing rules and queues expected frames.
   always @(posedge clk) begin
      if (rst) begin
         fr_valid = 1'b0;
         exp_q.delete();
         abort  = 1'b1;
         chk_en = 1'b1;
      end else if (bus.tx_start && (!fr_valid || cyc >= cur.n + F)) begin
         cur.data = bus.tx_data;
         cur.n    = cyc;
         fr_valid = 1'b1;
         exp_q.push_back(cur);
      end
      cyc++;
   end

   // Monitor: per-cycle waveform check plus a line decoder that pops the scoreboard on tx_done.
   always @(negedge clk) begin
      if (chk_en) begin
         el = 1'b1; eb = 1'b0; ed = 1'b0;
         if (fr_valid && cyc >= cur.n + 1 && cyc <= cur.n + F) begin
            k  = (cyc - cur.n - 1) / P;
            eb = 1'b1;
            ed = (cyc == cur.n + F);
            if (k == 0) el = 1'b0;
            else if (k <= 8) el = cur.data[k-1];
`ifdef UART_TX_PARITY_EN
            else if (k == 9) el = ^cur.data;
`endif
            else el = 1'b1;
         end
         check("line", 32'(bus.uart_tx), 32'(el));
         check("busy", 32'(bus.tx_busy), 32'(eb));
         check("done", 32'(bus.tx_done), 32'(ed));

         if (abort) begin
            dec_active = 1'b0;
            abort      = 1'b0;
         end
         if (!dec_active && bus.uart_tx === 1'b0) begin
            dec_active = 1'b1;
            dec_start  = cyc;
         end
         if (dec_active) begin
            off = cyc - dec_start;
            if (off % P == P / 2 && off / P >= 1 && off / P <= 8) dec_byte[off/P-1] = bus.uart_tx;
            if (off % P == P / 2 && off / P == 9) dec_par = bus.uart_tx;
         end
         if (bus.tx_done === 1'b1) begin
            check("done_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               popped = exp_q.pop_front();
               check("done_time", 32'(cyc), 32'(popped.n + F));
               check("byte", 32'(dec_byte), 32'(popped.data));
`ifdef UART_TX_PARITY_EN
               check("parity_bit", 32'(dec_par), 32'(^popped.data));
`endif
            end
            dec_active = 1'b0;
         end
      end
   end

   task automatic send(input logic [7:0] d);
      bus.tx_data  = d;
      bus.tx_start = 1'b1;
      @(negedge clk);
      bus.tx_start = 1'b0;
      bus.tx_data  = 8'($urandom);
   endtask

   task automatic wait_idle(input string nm);
      int n;
      n = 0;
      while (bus.tx_busy !== 1'b0 && n < 4 * F) begin
         @(negedge clk);
         n++;
      end
      check(nm, 32'(bus.tx_busy), 32'd0);
   endtask

   task automatic wait_done(input string nm);
      int n;
      n = 0;
      while (bus.tx_done !== 1'b1 && n < 4 * F) begin
         @(negedge clk);
         n++;
      end
      check(nm, 32'(bus.tx_done), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   initial begin
      int mode;
      rst          = 1'b1;
      bus.tx_start = 1'b0;
      bus.tx_data  = 8'h00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      send(8'h55);
      wait_idle("idle_after_55");

      // Back-to-back: second request held through the done cycle.
      bus.tx_data  = 8'hA5;
      bus.tx_start = 1'b1;
      @(negedge clk);
      bus.tx_data = 8'h3C;
      wait_done("b2b_first_done");
      @(negedge clk);
      bus.tx_start = 1'b0;
      wait_idle("idle_after_b2b");

      // Request while busy must be dropped.
      send(8'h00);
      repeat (38) @(negedge clk);
      send(8'hFF);
      wait_idle("idle_after_ignore");

      // Reset in the middle of a frame, then a clean frame.
      send(8'hC3);
      repeat (33) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      send(8'h81);
      wait_idle("idle_after_reset");

      send(8'h07);
      wait_idle("idle_after_07");

      for (int i = 0; i < 30; i++) begin
         mode = int'($urandom_range(0, 2));
         case (mode)
            0: begin
               send(8'($urandom));
               wait_idle("idle_rand_single");
            end
            1: begin
               bus.tx_data  = 8'($urandom);
               bus.tx_start = 1'b1;
               @(negedge clk);
               bus.tx_data = 8'($urandom);
               wait_done("rand_b2b_done");
               @(negedge clk);
               bus.tx_start = 1'b0;
               wait_idle("idle_rand_b2b");
            end
            default: begin
               send(8'($urandom));
               repeat ($urandom_range(0, F)) @(negedge clk);
               send(8'($urandom));
               wait_idle("idle_rand_overlap");
            end
         endcase
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      repeat (5) @(negedge clk);
      check("queue_drain", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
